// File: rtl/student_iis_pkg.sv
// rtl/student_iis_pkg.sv - shared types and helpers for the student_iis transmitter
package student_iis_pkg;

  typedef enum logic [1:0] {
    S_SYNC,
    S_GAP,
    S_DATA,
    S_PAD
  } iis_tx_state_e;

  // Width of the per-slot bit counter; never narrower than one bit
  function automatic int bit_cnt_width(input int word_width);
    return (word_width > 1) ? $clog2(word_width) : 1;
  endfunction

  // Shift count that places half an output LSB in input-word units
  function automatic int round_half_shift(input int in_width, input int word_width);
    return in_width - word_width - 1;
  endfunction

endpackage

// File: rtl/student_iis_tx_conv.sv
// rtl/student_iis_tx_conv.sv - FIR word to slot word conversion (rounding option: STUDENT_IIS_TX_ROUND_EN)
module student_iis_tx_conv
  import student_iis_pkg::*;
#(
  parameter int IN_WIDTH   = 24,
  parameter int WORD_WIDTH = 16
) (
  input  logic signed [IN_WIDTH-1:0]   sample_in,
  output logic        [WORD_WIDTH-1:0] word_out
);

  localparam int SHIFT = IN_WIDTH - WORD_WIDTH;

  if (SHIFT == 0) begin : g_pass
    assign word_out = sample_in;
  end else begin : g_conv
`ifdef STUDENT_IIS_TX_ROUND_EN
    localparam int HALF_SHIFT = round_half_shift(IN_WIDTH, WORD_WIDTH);
    localparam logic [IN_WIDTH:0]     HALF     = {{IN_WIDTH{1'b0}}, 1'b1} << HALF_SHIFT;
    localparam logic [WORD_WIDTH-1:0] WORD_MAX = {1'b0, {(WORD_WIDTH-1){1'b1}}};
    localparam logic [WORD_WIDTH-1:0] WORD_MIN = {1'b1, {(WORD_WIDTH-1){1'b0}}};

    logic [IN_WIDTH:0] sum;
    logic [SHIFT-1:0]  unused_frac;

    // One guard bit above the sign lets the half-LSB add overflow visibly instead of wrapping
    assign sum         = {sample_in[IN_WIDTH-1], sample_in} + HALF;
    assign unused_frac = sum[SHIFT-1:0];

    // Saturate when guard and sign disagree, otherwise keep the rounded upper bits
    always_comb begin
      if (sum[IN_WIDTH] != sum[IN_WIDTH-1]) begin
        word_out = sum[IN_WIDTH] ? WORD_MIN : WORD_MAX;
      end else begin
        word_out = sum[IN_WIDTH-1:SHIFT];
      end
    end
`else
    logic [SHIFT-1:0] unused_frac;

    // Arithmetic right shift then truncate is simply the upper slice
    assign unused_frac = sample_in[SHIFT-1:0];
    assign word_out    = sample_in[IN_WIDTH-1:SHIFT];
`endif
  end

endmodule

// File: rtl/student_iis_tx.sv
// rtl/student_iis_tx.sv - mono-in stereo-out I2S DAC transmitter (rounding option: STUDENT_IIS_TX_ROUND_EN)
module student_iis_tx
  import student_iis_pkg::*;
#(
  parameter int IN_WIDTH   = 24,
  parameter int WORD_WIDTH = 16,
  parameter int SLOT_BITS  = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                valid_strobe_in,
  input  logic [IN_WIDTH-1:0] sample_in,
  input  logic                BCLK_Fall,
  input  logic                LRCLK_Fall,
  input  logic                LRCLK_Rise,
  output logic                AC_DACDAT,
  output logic                overrun_o,
  output logic                underrun_o,
  output logic                busy_o
);

  if (WORD_WIDTH > IN_WIDTH) begin : g_bad_word_width
    $error("student_iis_tx: WORD_WIDTH must not exceed IN_WIDTH");
  end
  if (SLOT_BITS < WORD_WIDTH + 1) begin : g_bad_slot_bits
    $error("student_iis_tx: SLOT_BITS must leave room for the delay bit plus the word");
  end

  localparam int CNT_W = bit_cnt_width(WORD_WIDTH);
  localparam logic [CNT_W-1:0] CNT_MSB = CNT_W'(WORD_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WORD_WIDTH-1:0] conv_word;
  logic [WORD_WIDTH-1:0] pending;
  logic                  pending_vld;
  logic [WORD_WIDTH-1:0] frame;
  logic                  consume;
  iis_tx_state_e         state;
  logic [CNT_W-1:0]      bit_cnt;

  student_iis_tx_conv #(
    .IN_WIDTH  (IN_WIDTH),
    .WORD_WIDTH(WORD_WIDTH)
  ) u_conv (
    .sample_in(sample_in),
    .word_out (conv_word)
  );

  // A left-slot start takes the pending word if one is waiting
  assign consume = LRCLK_Fall && pending_vld;

  // Sample capture, frame load and overrun/underrun flagging
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending     <= '0;
      pending_vld <= 1'b0;
      frame       <= '0;
      overrun_o   <= 1'b0;
      underrun_o  <= 1'b0;
    end else begin
      overrun_o  <= valid_strobe_in && pending_vld && !consume;
      underrun_o <= LRCLK_Fall && !pending_vld;
      if (valid_strobe_in) begin
        pending     <= conv_word;
        pending_vld <= 1'b1;
      end else if (consume) begin
        pending_vld <= 1'b0;
      end
      if (consume) begin
        frame <= pending;
      end
    end
  end

  // Slot sequencer: advances only on BCLK falling edges, outputs registered
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_SYNC;
      bit_cnt    <= '0;
      AC_DACDAT  <= 1'b0;
      busy_o     <= 1'b0;
    end else if (BCLK_Fall) begin
      if (LRCLK_Fall || (LRCLK_Rise && state != S_SYNC)) begin
        state     <= S_GAP;
        AC_DACDAT <= 1'b0;
        busy_o    <= 1'b0;
      end else begin
        unique case (state)
          S_SYNC: begin
            AC_DACDAT <= 1'b0;
            busy_o    <= 1'b0;
          end
          S_GAP: begin
            state     <= S_DATA;
            bit_cnt   <= CNT_MSB;
            AC_DACDAT <= frame[CNT_MSB];
            busy_o    <= 1'b1;
          end
          S_DATA: begin
            if (bit_cnt == '0) begin
              state     <= S_PAD;
              AC_DACDAT <= 1'b0;
              busy_o    <= 1'b0;
            end else begin
              bit_cnt   <= bit_cnt - CNT_ONE;
              AC_DACDAT <= frame[bit_cnt - CNT_ONE];
            end
          end
          S_PAD: begin
            AC_DACDAT <= 1'b0;
            busy_o    <= 1'b0;
          end
          default: begin
            state     <= S_SYNC;
            AC_DACDAT <= 1'b0;
            busy_o    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_student_iis_tx.sv
// tb/tb_student_iis_tx.sv - scoreboard bench for student_iis_tx
module tb_student_iis_tx;

  localparam int IN_WIDTH   = 24;
  localparam int WORD_WIDTH = 16;
  localparam int SLOT_BITS  = 32;
  localparam int BCLK_DIV   = 4;
  localparam int NPAT       = 6;

  logic                clk;
  logic                rst_i;
  logic                valid_strobe_in;
  logic [IN_WIDTH-1:0] sample_in;
  logic                BCLK_Fall;
  logic                LRCLK_Fall;
  logic                LRCLK_Rise;
  logic                AC_DACDAT;
  logic                overrun_o;
  logic                underrun_o;
  logic                busy_o;

  int checks    = 0;
  int passed    = 0;
  int under_cnt = 0;
  int over_cnt  = 0;
  bit mon_en    = 1'b0;

  logic [WORD_WIDTH-1:0] exp_q[$];

  int gen_ph   = 0;
  int gen_bit  = 0;
  bit gen_left = 1'b1;

  logic [IN_WIDTH-1:0]   pat_in [NPAT] = '{24'h7FFFFF, 24'h0000FF, 24'hFFFF7F,
                                           24'h800000, 24'h123480, 24'hFFFF80};
`ifdef STUDENT_IIS_TX_ROUND_EN
  logic [WORD_WIDTH-1:0] pat_exp[NPAT] = '{16'h7FFF, 16'h0001, 16'hFFFF,
                                           16'h8000, 16'h1235, 16'h0000};
`else
  logic [WORD_WIDTH-1:0] pat_exp[NPAT] = '{16'h7FFF, 16'h0000, 16'hFFFF,
                                           16'h8000, 16'h1234, 16'hFFFF};
`endif

  student_iis_tx #(
    .IN_WIDTH  (IN_WIDTH),
    .WORD_WIDTH(WORD_WIDTH),
    .SLOT_BITS (SLOT_BITS)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .valid_strobe_in(valid_strobe_in),
    .sample_in      (sample_in),
    .BCLK_Fall      (BCLK_Fall),
    .LRCLK_Fall     (LRCLK_Fall),
    .LRCLK_Rise     (LRCLK_Rise),
    .AC_DACDAT      (AC_DACDAT),
    .overrun_o      (overrun_o),
    .underrun_o     (underrun_o),
    .busy_o         (busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Clock-gen model: BCLK falls every BCLK_DIV cycles, LRCLK toggles every SLOT_BITS BCLKs
  initial begin
    BCLK_Fall  = 1'b0;
    LRCLK_Fall = 1'b0;
    LRCLK_Rise = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      BCLK_Fall  = (gen_ph == 0);
      LRCLK_Fall = (gen_ph == 0) && (gen_bit == 0) && gen_left;
      LRCLK_Rise = (gen_ph == 0) && (gen_bit == 0) && !gen_left;
      gen_ph++;
      if (gen_ph == BCLK_DIV) begin
        gen_ph = 0;
        gen_bit++;
        if (gen_bit == SLOT_BITS) begin
          gen_bit  = 0;
          gen_left = !gen_left;
        end
      end
    end
  end

  // Deserialise each slot and compare against the scoreboard
  initial begin : monitor
    bit bf, lf, lr, frame_chk, slot_chk, fmt_err, exp_busy;
    int idx;
    logic [WORD_WIDTH-1:0] word, exp_w;
    idx = 0; frame_chk = 0; slot_chk = 0; fmt_err = 0; word = '0;
    forever begin
      @(posedge clk);
      bf = BCLK_Fall; lf = LRCLK_Fall; lr = LRCLK_Rise;
      @(negedge clk);
      if (underrun_o === 1'b1) under_cnt++;
      if (overrun_o === 1'b1) over_cnt++;
      if (bf) begin
        if (lf || lr) begin
          idx = 0;
          if (lf) frame_chk = mon_en;
          slot_chk = frame_chk;
          word     = '0;
          fmt_err  = 0;
        end else begin
          idx++;
        end
        if (idx >= 1 && idx <= WORD_WIDTH) word = {word[WORD_WIDTH-2:0], AC_DACDAT};
        else if (AC_DACDAT !== 1'b0) fmt_err = 1;
        exp_busy = (idx >= 1 && idx <= WORD_WIDTH);
        if (busy_o !== exp_busy) fmt_err = 1;
        if (slot_chk && idx == SLOT_BITS - 1) begin
          slot_chk = 0;
          checks++;
          if (exp_q.size() == 0) begin
            $display("FAIL slot_unexpected got %h required no slot", word);
          end else begin
            exp_w = exp_q.pop_front();
            if (word !== exp_w) $display("FAIL slot_word got %h required %h", word, exp_w);
            else passed++;
            checks++;
            if (fmt_err !== 1'b0) $display("FAIL slot_format got gap/pad/busy error %0d required 0", fmt_err);
            else passed++;
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_lf();
    int n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (!LRCLK_Fall && n < 700);
    if (!LRCLK_Fall) begin
      checks++;
      $display("FAIL wait_lrclk_fall got timeout after %0d cycles required an LRCLK_Fall", n);
    end
  endtask

  task automatic pulse(input logic [IN_WIDTH-1:0] s);
    sample_in       = s;
    valid_strobe_in = 1'b1;
    step(1);
    valid_strobe_in = 1'b0;
  endtask

  task automatic push2(input logic [WORD_WIDTH-1:0] w);
    exp_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic wait_empty();
    int n = 0;
    while (exp_q.size() != 0 && n < 1400) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL scoreboard_drain got %0d slots outstanding required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; valid_strobe_in = 1'b0; sample_in = '0;
    step(3);
    @(negedge clk);
    checks++; if (AC_DACDAT !== 1'b0) $display("FAIL reset_dacdat got %b required 0", AC_DACDAT); else passed++;
    checks++; if (overrun_o !== 1'b0) $display("FAIL reset_overrun got %b required 0", overrun_o); else passed++;
    checks++; if (underrun_o !== 1'b0) $display("FAIL reset_underrun got %b required 0", underrun_o); else passed++;
    checks++; if (busy_o !== 1'b0) $display("FAIL reset_busy got %b required 0", busy_o); else passed++;
    wait_lf();
    step(8);
    rst_i = 1'b0;
  endtask

  task automatic test_basic();
    under_cnt = 0; over_cnt = 0;
    pulse(24'h123456);
    push2(16'h1234);
    wait_lf();
    mon_en = 1'b1;
    wait_empty();
    checks++; if (under_cnt !== 0) $display("FAIL basic_underrun got %0d required 0", under_cnt); else passed++;
    checks++; if (over_cnt !== 0) $display("FAIL basic_overrun got %0d required 0", over_cnt); else passed++;
  endtask

  task automatic test_underrun();
    wait_lf();
    under_cnt = 0; over_cnt = 0;
    push2(16'h1234);
    wait_empty();
    checks++; if (under_cnt !== 1) $display("FAIL underrun_count got %0d required 1", under_cnt); else passed++;
    checks++; if (over_cnt !== 0) $display("FAIL underrun_overrun got %0d required 0", over_cnt); else passed++;
  endtask

  task automatic test_overrun();
    wait_lf();
    under_cnt = 0; over_cnt = 0;
    push2(16'h1234);
    step(20);
    pulse(24'h000100);
    step(5);
    pulse(24'hFFFF00);
    push2(16'hFFFF);
    wait_empty();
    checks++; if (over_cnt !== 1) $display("FAIL overrun_count got %0d required 1", over_cnt); else passed++;
    checks++; if (under_cnt !== 1) $display("FAIL overrun_underrun got %0d required 1", under_cnt); else passed++;
  endtask

  task automatic test_coincident();
    wait_lf();
    under_cnt = 0; over_cnt = 0;
    push2(16'hFFFF);
    step(20);
    pulse(24'h0ABC12);
    wait_lf();
    pulse(24'hF12345);
    push2(16'h0ABC);
    push2(16'hF123);
    wait_empty();
    checks++; if (over_cnt !== 0) $display("FAIL coincident_overrun got %0d required 0", over_cnt); else passed++;
    checks++; if (under_cnt !== 1) $display("FAIL coincident_underrun got %0d required 1", under_cnt); else passed++;
  endtask

  task automatic test_conversion();
    logic [WORD_WIDTH-1:0] prev = 16'hF123;
    under_cnt = 0; over_cnt = 0;
    for (int i = 0; i <= NPAT; i++) begin
      wait_lf();
      push2(prev);
      if (i < NPAT) begin
        step(20);
        pulse(pat_in[i]);
        prev = pat_exp[i];
      end
    end
    wait_empty();
    checks++; if (under_cnt !== 1) $display("FAIL conversion_underrun got %0d required 1", under_cnt); else passed++;
    checks++; if (over_cnt !== 0) $display("FAIL conversion_overrun got %0d required 0", over_cnt); else passed++;
  endtask

  task automatic test_reset_mid_data();
    bit bad = 0;
    int n = 0;
    mon_en = 1'b0;
    wait_lf();
    step(10);
    pulse(24'h7FFF00);
    step(8);
    @(negedge clk);
    checks++; if (busy_o !== 1'b1) $display("FAIL midreset_busy_before got %b required 1", busy_o); else passed++;
    @(posedge clk);
    #2;
    rst_i = 1'b1;
    step(1);
    rst_i = 1'b0;
    @(negedge clk);
    checks++; if (AC_DACDAT !== 1'b0) $display("FAIL midreset_dacdat got %b required 0", AC_DACDAT); else passed++;
    checks++; if (busy_o !== 1'b0) $display("FAIL midreset_busy got %b required 0", busy_o); else passed++;
    do begin
      @(posedge clk);
      #2;
      n++;
      if (AC_DACDAT !== 1'b0 || busy_o !== 1'b0) bad = 1;
    end while (!LRCLK_Fall && n < 700);
    checks++; if (bad !== 1'b0 || !LRCLK_Fall) $display("FAIL midreset_quiet got activity %0d lrclk_fall %0d required 0 and 1", bad, LRCLK_Fall); else passed++;
    mon_en = 1'b1;
    under_cnt = 0; over_cnt = 0;
    push2(16'h0000);
    wait_empty();
    checks++; if (under_cnt !== 1) $display("FAIL midreset_underrun got %0d required 1", under_cnt); else passed++;
    checks++; if (over_cnt !== 0) $display("FAIL midreset_overrun got %0d required 0", over_cnt); else passed++;
  endtask

  initial begin
    rst_i           = 1'b1;
    valid_strobe_in = 1'b0;
    sample_in       = '0;
    test_reset();
    test_basic();
    test_underrun();
    test_overrun();
    test_coincident();
    test_conversion();
    test_reset_mid_data();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/student_iis_tx.md
Name: student_iis_tx

Overview:
- I2S transmitter directly downstream of student_fir.
- Captures the FIR result (y_out / valid_strobe_out) and serialises it MSB-first onto the codec DAC data line, using the bit/frame strobes from student_iis_clock_gen.
- Mono in, stereo out: the same word is sent in the left and right slots.
- Buffers one sample across the LRCLK frame boundary and flags overrun and underrun.

Parameters:
- IN_WIDTH, 24, width of the signed FIR output word (matches DATA_SIZE_FIR_OUT).
- WORD_WIDTH, 16, bits transmitted per channel slot; must satisfy WORD_WIDTH <= IN_WIDTH.
- SLOT_BITS, 32, BCLK periods per channel (half LRCLK period); must satisfy SLOT_BITS >= WORD_WIDTH+1.

Ports:
- clk_i  in  1  system clock; all logic on posedge.
- rst_i  in  1  synchronous, active-high reset.
- valid_strobe_in  in  1  one-cycle pulse; sample_in valid.
- sample_in  in  IN_WIDTH  signed FIR result.
- BCLK_Fall  in  1  one-cycle strobe at each BCLK falling edge.
- LRCLK_Fall  in  1  start of left slot; always coincident with a BCLK_Fall.
- LRCLK_Rise  in  1  start of right slot; always coincident with a BCLK_Fall.
- AC_DACDAT  out  1  serial data to codec.
- overrun_o  out  1  one-cycle pulse: sample dropped.
- underrun_o  out  1  one-cycle pulse: frame started with no new sample.
- busy_o  out  1  high while data bits of a slot are being shifted.

Behaviour:
- Reset values:
  - AC_DACDAT=0, overrun_o=0, underrun_o=0, busy_o=0.
  - pending register=0, pending_vld=0, frame register=0, FSM=S_SYNC.
- Capture:
  - On valid_strobe_in: pending <= conv(sample_in), pending_vld <= 1.
  - If pending_vld was already 1 and is not consumed in this same cycle, overrun_o pulses the next cycle; the newest sample wins.
- Conversion conv():
  - Arithmetic right shift by IN_WIDTH-WORD_WIDTH (plain truncation); see the optional feature for rounding.
  - WORD_WIDTH==IN_WIDTH is a pass-through.
- Frame load, on LRCLK_Fall:
  - If pending_vld: frame <= pending, pending_vld <= 0.
  - Otherwise: frame is kept (last word repeated) and underrun_o pulses.
  - If valid_strobe_in coincides with LRCLK_Fall, the incoming sample goes to pending and is not used for this frame. No overrun is flagged if pending was consumed in that cycle.
- FSM, evaluated only on BCLK_Fall cycles (holds otherwise):
  - S_SYNC: AC_DACDAT=0. The first LRCLK_Fall after reset goes to S_GAP. LRCLK_Rise is ignored in S_SYNC, so transmission always starts on a left slot.
  - S_GAP: I2S one-bit delay; AC_DACDAT=0. Next BCLK_Fall goes to S_DATA with bit_cnt=WORD_WIDTH-1.
  - S_DATA: AC_DACDAT=frame[bit_cnt]; busy_o=1; bit_cnt decrements. After the bit_cnt==0 bit goes to S_PAD.
  - S_PAD: AC_DACDAT=0 until the next LRCLK edge.
- LRCLK edges in any state other than S_SYNC force S_GAP and restart the slot. A mid-slot edge (clock-gen resync) truncates the current word; no error flag is raised.
- LRCLK_Rise reuses the same frame word for the right slot; it performs no load.
- Outputs are registered: AC_DACDAT changes on the clk_i cycle after the BCLK_Fall strobe.
- Reset asserted mid-slot: AC_DACDAT=0 next cycle; returns to S_SYNC; the pending sample is lost.

Optional Feature:
- Macro: STUDENT_IIS_TX_ROUND_EN.
- When defined, conv() adds the half-LSB 2^(IN_WIDTH-WORD_WIDTH-1) before the shift and saturates to the WORD_WIDTH signed range.
  - Example: IN 24'h7FFFFF -> 16'h7FFF, no wrap.
- When undefined, conv() is plain arithmetic truncation.
- Ports and latency are identical in both builds.

Decomposition:
- Package student_iis_pkg:
  - FSM enum iis_tx_state_e {S_SYNC, S_GAP, S_DATA, S_PAD}.
  - Function for the width of bit_cnt ($clog2(WORD_WIDTH)).
  - Rounding constants.
- Sub-module student_iis_tx_conv: combinational truncate/round/saturate. Keeps the macro-dependent arithmetic separate from the FSM.

Test Plan:
- Basic frame:
  - Stimulus: reset, then sample_in=24'h123456 with strobe before the first LRCLK_Fall.
  - Response: left slot shows one 0 bit, then 16'h1234 MSB-first, then zeros to slot end. The right slot repeats 16'h1234.
- Underrun:
  - Stimulus: no strobe before the second LRCLK_Fall.
  - Response: underrun_o pulses once; both slots resend 16'h1234.
- Overrun:
  - Stimulus: strobes with 24'h000100 then 24'hFFFF00 within one frame.
  - Response: overrun_o pulses once; the next frame carries 16'hFFFF.
- Rounding/saturation, with STUDENT_IIS_TX_ROUND_EN defined:
  - 24'h7FFFFF -> 16'h7FFF.
  - 24'h0000FF -> 16'h0001.
  - 24'hFFFF7F -> 16'hFFFF.
  - Without the macro, 24'h0000FF -> 16'h0000.
- Coincident events:
  - Stimulus: valid_strobe_in on the same cycle as LRCLK_Fall with pending valid.
  - Response: old pending is sent this frame; the new sample is sent next frame; no overrun.
- Reset mid-S_DATA:
  - Stimulus: rst_i high for 1 cycle.
  - Response: AC_DACDAT=0 and busy_o=0 next cycle; output stays 0 (ignoring LRCLK_Rise) until the next LRCLK_Fall.
